ysyx_22050078_stbuf: RTL and testbench

Store buffer between the load/store unit and the data-memory write port of the RV64 core. It accepts store requests (address, data, byte mask) from the LSU through a valid/ready handshake and queues them in a small in-order FIFO. It drains them to memory through a second valid/ready handshake. It also flags loads that hit a pending store so the pipeline stalls the load until the store has drained, which keeps read-after-write ordering correct.

---
 rtl/ysyx_22050078_stbuf.sv | 106 ++++++++++
 tb/tb_ysyx_22050078_stbuf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050078_stbuf.sv
// In-order store buffer between the LSU and the data-memory write port.
// Queues masked stores, drains them oldest-first and flags loads that hit a pending store.
module ysyx_22050078_stbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_st_valid,
  output logic                       o_st_ready,
  input  logic [AW-1:0]              i_st_addr,
  input  logic [DW-1:0]              i_st_data,
  input  logic [DW/8-1:0]            i_st_wmask,
  input  logic                       i_ld_valid,
  input  logic [AW-1:0]              i_ld_addr,
  output logic                       o_ld_stall,
  output logic                       o_mem_valid,
  input  logic                       i_mem_ready,
  output logic [AW-1:0]              o_mem_addr,
  output logic [DW-1:0]              o_mem_data,
  output logic [DW/8-1:0]            o_mem_wmask,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = DW / 8;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [MW-1:0] mask_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          hit;
  logic          unused_ld_lo;

  // An index is live when it lies within count slots of the read pointer (mod DEPTH).
  function automatic logic slot_live(input logic [PW-1:0] idx,
                                     input logic [PW-1:0] rd,
                                     input logic [CW-1:0] cnt);
    logic [PW-1:0] offs;
    offs = idx - rd;
    return ({1'b0, offs} < cnt);
  endfunction

  assign o_st_ready  = !rst && (count != CW'(DEPTH));
  assign push        = i_st_valid && o_st_ready && (i_st_wmask != '0);
  assign o_mem_valid = (count != '0);
  assign pop         = o_mem_valid && i_mem_ready;
  assign o_mem_addr  = addr_q[rd_ptr];
  assign o_mem_data  = data_q[rd_ptr];
  assign o_mem_wmask = mask_q[rd_ptr];
  assign o_count     = count;
  assign o_empty     = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= i_st_addr;
        data_q[wr_ptr] <= i_st_data;
        mask_q[wr_ptr] <= i_st_wmask;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Load conflict check at doubleword granularity against live entries and the incoming store.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_live(PW'(i), rd_ptr, count) &&
          (addr_q[i][AW-1:3] == i_ld_addr[AW-1:3])) begin
        hit = 1'b1;
      end
    end
    if (push && (i_st_addr[AW-1:3] == i_ld_addr[AW-1:3])) begin
      hit = 1'b1;
    end
  end

  assign o_ld_stall   = i_ld_valid && hit;
  assign unused_ld_lo = ^i_ld_addr[2:0];

endmodule

// File: tb/tb_ysyx_22050078_stbuf.sv
// Directed bench for the store buffer: per-cycle vector table plus reset/recovery sequences.
module tb_ysyx_22050078_stbuf;

  logic        clk;
  logic        rst;
  logic        i_st_valid;
  logic        o_st_ready;
  logic [63:0] i_st_addr;
  logic [63:0] i_st_data;
  logic [7:0]  i_st_wmask;
  logic        i_ld_valid;
  logic [63:0] i_ld_addr;
  logic        o_ld_stall;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_data;
  logic [7:0]  o_mem_wmask;
  logic [2:0]  o_count;
  logic        o_empty;

  int checks = 0;
  int errors = 0;

  ysyx_22050078_stbuf #(.DEPTH(4), .AW(64), .DW(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_st_valid (i_st_valid),
    .o_st_ready (o_st_ready),
    .i_st_addr  (i_st_addr),
    .i_st_data  (i_st_data),
    .i_st_wmask (i_st_wmask),
    .i_ld_valid (i_ld_valid),
    .i_ld_addr  (i_ld_addr),
    .o_ld_stall (o_ld_stall),
    .o_mem_valid(o_mem_valid),
    .i_mem_ready(i_mem_ready),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_wmask(o_mem_wmask),
    .o_count    (o_count),
    .o_empty    (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [63:0] sa;
    logic [7:0]  sm;
    logic        lv;
    logic [63:0] la;
    logic        mr;
    logic        e_rdy;
    logic        e_stall;
    logic        e_mv;
    logic [63:0] e_ma;
    logic [7:0]  e_mm;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] dat(input logic [63:0] a);
    return {a[31:0], ~a[31:0]};
  endfunction

  task automatic add(input logic sv, input logic [63:0] sa, input logic [7:0] sm,
                     input logic lv, input logic [63:0] la, input logic mr,
                     input logic e_rdy, input logic e_stall, input logic e_mv,
                     input logic [63:0] e_ma, input logic [7:0] e_mm, input logic [2:0] e_cnt);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sm = sm; v.lv = lv; v.la = la; v.mr = mr;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_mv = e_mv;
    v.e_ma = e_ma; v.e_mm = e_mm; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [63:0] sa, input logic [7:0] sm,
                       input logic lv, input logic [63:0] la, input logic mr);
    i_st_valid  = sv;
    i_st_addr   = sa;
    i_st_data   = dat(sa);
    i_st_wmask  = sm;
    i_ld_valid  = lv;
    i_ld_addr   = la;
    i_mem_ready = mr;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 8'h00, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    // sv sa sm | lv la | mr || rdy stall mv ma mm cnt
    // Three stores held by backpressure, then drained in order
    add(1, 64'h80000000, 8'h01, 0, 0, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    add(1, 64'h80000008, 8'h03, 0, 0, 0,  1, 0, 1, 64'h80000000, 8'h01, 3'd1);
    add(1, 64'h80000010, 8'hFF, 0, 0, 0,  1, 0, 1, 64'h80000000, 8'h01, 3'd2);
    add(0, 64'h0,        8'h00, 0, 0, 0,  1, 0, 1, 64'h80000000, 8'h01, 3'd3);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h80000000, 8'h01, 3'd3);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h80000008, 8'h03, 3'd2);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h80000010, 8'hFF, 3'd1);
    add(0, 64'h0,        8'h00, 0, 0, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    // Fill to full, blocked 5th store, single pop, then 5th accepted and drains last
    add(1, 64'h100,      8'h01, 0, 0, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    add(1, 64'h200,      8'h01, 0, 0, 0,  1, 0, 1, 64'h100,      8'h01, 3'd1);
    add(1, 64'h300,      8'h01, 0, 0, 0,  1, 0, 1, 64'h100,      8'h01, 3'd2);
    add(1, 64'h400,      8'h01, 0, 0, 0,  1, 0, 1, 64'h100,      8'h01, 3'd3);
    add(1, 64'h500,      8'h01, 0, 0, 0,  0, 0, 1, 64'h100,      8'h01, 3'd4);
    add(1, 64'h500,      8'h01, 0, 0, 1,  0, 0, 1, 64'h100,      8'h01, 3'd4);
    add(1, 64'h500,      8'h01, 0, 0, 0,  1, 0, 1, 64'h200,      8'h01, 3'd3);
    add(0, 64'h0,        8'h00, 0, 0, 1,  0, 0, 1, 64'h200,      8'h01, 3'd4);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h300,      8'h01, 3'd3);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h400,      8'h01, 3'd2);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h500,      8'h01, 3'd1);
    add(0, 64'h0,        8'h00, 0, 0, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    // Load hazard against a queued store, neighbouring doublewords, after drain
    add(1, 64'h80001004, 8'h0F, 0, 0,            0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    add(0, 64'h0,        8'h00, 1, 64'h80001000, 0,  1, 1, 1, 64'h80001004, 8'h0F, 3'd1);
    add(0, 64'h0,        8'h00, 1, 64'h80001008, 0,  1, 0, 1, 64'h80001004, 8'h0F, 3'd1);
    add(0, 64'h0,        8'h00, 1, 64'h80000FF8, 0,  1, 0, 1, 64'h80001004, 8'h0F, 3'd1);
    add(0, 64'h0,        8'h00, 0, 0,            1,  1, 0, 1, 64'h80001004, 8'h0F, 3'd1);
    add(0, 64'h0,        8'h00, 1, 64'h80001000, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    // Same-cycle push and load into an empty buffer; stale slot must not stall
    add(1, 64'h80002000, 8'h01, 1, 64'h80002006, 0,  1, 1, 0, 64'h0,        8'h00, 3'd0);
    add(0, 64'h0,        8'h00, 1, 64'h80002000, 1,  1, 1, 1, 64'h80002000, 8'h01, 3'd1);
    add(0, 64'h0,        8'h00, 1, 64'h80002000, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    // Zero-mask store is consumed but never queued and never stalls a load
    add(1, 64'h80003000, 8'h00, 1, 64'h80003000, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    add(0, 64'h0,        8'h00, 0, 0,            0,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    // Streaming with memory always ready keeps occupancy at most one
    add(1, 64'h600,      8'hF0, 0, 0, 1,  1, 0, 0, 64'h0,        8'h00, 3'd0);
    add(1, 64'h608,      8'hF0, 0, 0, 1,  1, 0, 1, 64'h600,      8'hF0, 3'd1);
    add(1, 64'h610,      8'hF0, 0, 0, 1,  1, 0, 1, 64'h608,      8'hF0, 3'd1);
    add(0, 64'h0,        8'h00, 0, 0, 1,  1, 0, 1, 64'h610,      8'hF0, 3'd1);
    add(0, 64'h0,        8'h00, 0, 0, 0,  1, 0, 0, 64'h0,        8'h00, 3'd0);

    // Reset state
    rst = 1'b1;
    idle();
    i_ld_valid = 1'b1;
    i_ld_addr  = 64'h0;
    #3;
    chk("rst mem_valid", o_mem_valid, 1'b0);
    chk("rst count",     o_count,     3'd0);
    chk("rst empty",     o_empty,     1'b1);
    chk("rst st_ready",  o_st_ready,  1'b0);
    chk("rst ld_stall",  o_ld_stall,  1'b0);
    chk("rst mem_addr",  o_mem_addr,  64'h0);
    chk("rst mem_data",  o_mem_data,  64'h0);
    chk("rst mem_wmask", o_mem_wmask, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    #1;
    chk("post-rst st_ready", o_st_ready, 1'b1);

    foreach (vq[i]) begin
      drive(vq[i].sv, vq[i].sa, vq[i].sm, vq[i].lv, vq[i].la, vq[i].mr);
      #2;
      chk($sformatf("v%0d st_ready", i),  o_st_ready,  vq[i].e_rdy);
      chk($sformatf("v%0d ld_stall", i),  o_ld_stall,  vq[i].e_stall);
      chk($sformatf("v%0d mem_valid", i), o_mem_valid, vq[i].e_mv);
      chk($sformatf("v%0d count", i),     o_count,     vq[i].e_cnt);
      chk($sformatf("v%0d empty", i),     o_empty,     (vq[i].e_cnt == 3'd0));
      if (vq[i].e_mv) begin
        chk($sformatf("v%0d mem_addr", i),  o_mem_addr,  vq[i].e_ma);
        chk($sformatf("v%0d mem_data", i),  o_mem_data,  dat(vq[i].e_ma));
        chk($sformatf("v%0d mem_wmask", i), o_mem_wmask, vq[i].e_mm);
      end
      @(posedge clk); #1;
    end

    // Mid-stream reset discards two queued stores, including the held head
    drive(1'b1, 64'h700, 8'h11, 1'b0, 64'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 64'h800, 8'h22, 1'b0, 64'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    #1;
    chk("pre-rst count",     o_count,    3'd2);
    chk("pre-rst mem_addr",  o_mem_addr, 64'h700);
    rst = 1'b1;
    i_ld_valid = 1'b1;
    i_ld_addr  = 64'h700;
    #1;
    chk("mid-rst mem_valid", o_mem_valid, 1'b0);
    chk("mid-rst count",     o_count,     3'd0);
    chk("mid-rst empty",     o_empty,     1'b1);
    chk("mid-rst st_ready",  o_st_ready,  1'b0);
    chk("mid-rst ld_stall",  o_ld_stall,  1'b0);
    chk("mid-rst mem_addr",  o_mem_addr,  64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    #1;
    chk("rel st_ready", o_st_ready, 1'b1);
    chk("rel count",    o_count,    3'd0);
    drive(1'b1, 64'h900, 8'h3C, 1'b0, 64'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    #1;
    chk("after-rst mem_valid", o_mem_valid, 1'b1);
    chk("after-rst mem_addr",  o_mem_addr,  64'h900);
    chk("after-rst mem_data",  o_mem_data,  dat(64'h900));
    chk("after-rst mem_wmask", o_mem_wmask, 8'h3C);
    chk("after-rst count",     o_count,     3'd1);
    i_mem_ready = 1'b1;
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    #1;
    chk("final empty",     o_empty,     1'b1);
    chk("final mem_valid", o_mem_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
